usart_tx_arbiter: RTL and testbench

//  Shares one USART transmitter among NUM_REQ byte sources.
//  - Sources use valid/ready handshakes. Arbitration is round-robin.
//  - Optional lock lets one source send a multi-byte packet without being interrupted.
//  - Drives the transmitter's toggle-start interface: a transfer starts when tx_enable changes level.
//  - Completion is a 1-cycle tx_response pulse from the transmitter.
//  - Sits between application producers and the USART transmitter.

---
 rtl/usart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_usart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter that shares one toggle-start USART transmitter among NUM_REQ byte sources.
// Supports a per-source lock for uninterrupted packets, an optional post-frame gap, and a frame counter.
module usart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int GAP_CLKS  = 0,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_enable,
    input  logic                           tx_response,
    output logic                           busy,
    output logic [CNT_W-1:0]               frames_sent
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP, FLUSH} state_t;

    // Not reset: the transmitter keeps its own copy of the toggle level across reset.
    state_t                 state     = IDLE;
    logic [DATA_BITS-1:0]   tx_data_r = '0;
    logic                   tx_en_r   = 1'b0;

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       lock_idx;
    logic                   lock_vld;
    logic [GAP_W-1:0]       gap_cnt;
    logic [IDX_W-1:0]       winner;
    logic                   found;
    int                     sel;

    assign tx_data   = tx_data_r;
    assign tx_enable = tx_en_r;
    assign busy      = (state != IDLE);

    // Scan downward so the last hit is the closest to ptr in round-robin order.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        sel    = 0;
        if (lock_vld) begin
            winner = lock_idx;
            found  = req_valid[lock_idx];
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                sel = (int'(ptr) + i) % NUM_REQ;
                if (req_valid[IDX_W'(sel)]) begin
                    winner = IDX_W'(sel);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // A frame already on the wire must still be drained before the next grant.
            state       <= (state == XFER || state == FLUSH) ? FLUSH : IDLE;
            ptr         <= '0;
            lock_vld    <= 1'b0;
            lock_idx    <= '0;
            grant       <= '0;
            frames_sent <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_data_r <= req_data[winner*DATA_BITS +: DATA_BITS];
                        tx_en_r   <= ~tx_en_r;
                        grant     <= NUM_REQ'(1) << winner;
                        ptr       <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        lock_vld  <= req_lock[winner];
                        lock_idx  <= winner;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (tx_response) begin
                        frames_sent <= frames_sent + 1'b1;
                        gap_cnt     <= '0;
                        state       <= (GAP_CLKS > 0) ? GAP : IDLE;
                        if (!lock_vld)
                            grant <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CLKS - 1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                FLUSH: begin
                    if (tx_response)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Bench for usart_tx_arbiter: queue-fed sources, a toggle-start transmitter model and a frame scoreboard.
// A second instance with GAP_CLKS=5 is driven by hand for gap timing.
module tb_usart_tx_arbiter;
    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int RESP_DLY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req_valid, req_lock, req_ready, grant;
    logic [N*DW-1:0]   req_data;
    logic [DW-1:0]     tx_data;
    logic              tx_enable, tx_response, busy;
    logic [1:0]        frames_sent;
    logic              resp_model, resp_spur;
    assign tx_response = resp_model | resp_spur;

    logic [N-1:0]      b_valid, b_lock, b_ready, b_grant;
    logic [N*DW-1:0]   b_data;
    logic [DW-1:0]     b_txd;
    logic              b_txe, b_resp, b_busy;
    logic [15:0]       b_frames;

    usart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .GAP_CLKS(0), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock), .req_data(req_data),
        .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_enable(tx_enable),
        .tx_response(tx_response), .busy(busy), .frames_sent(frames_sent));

    usart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .GAP_CLKS(5), .CNT_W(16)) dut_gap (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_lock(b_lock), .req_data(b_data),
        .req_ready(b_ready), .grant(b_grant), .tx_data(b_txd), .tx_enable(b_txe),
        .tx_response(b_resp), .busy(b_busy), .frames_sent(b_frames));

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW:0]     src_q [N][$];   // {lock, data} per source
    logic [N+DW-1:0] exp_q [$];      // {grant, data} expected per frame
    logic [N+DW-1:0] obs_q [$];
    int              obs_cyc [$];
    logic [N-1:0]    acc;
    logic            lvl, pend;
    int              cnt;

    function automatic logic [N-1:0] onehot(input int s);
        onehot = N'(1) << s;
    endfunction

    // Sources: present queue heads, pop what was accepted on the previous edge.
    initial begin
        req_valid = '0; req_lock = '0; req_data = '0; acc = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_lock[i]  = src_q[i][0][DW];
                    req_data[i*DW +: DW] = src_q[i][0][DW-1:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_lock[i]  = 1'b0;
                end
            end
            #1 acc = req_valid & req_ready & {N{~reset}};
        end
    end

    // Transmitter: each level change starts a frame that completes RESP_DLY cycles later.
    initial begin
        resp_model = 1'b0; lvl = 1'b0; pend = 1'b0; cnt = 0;
        forever begin
            @(negedge clk); #2;
            resp_model = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin resp_model = 1'b1; pend = 1'b0; end
            end
            if (tx_enable !== lvl) begin
                n_total++;
                if (pend) $display("FAIL toggle_while_busy got toggle at cycle %0d required none", cyc);
                else n_pass++;
                lvl = tx_enable;
                obs_q.push_back({grant, tx_data});
                obs_cyc.push_back(cyc);
                pend = 1'b1;
                cnt  = RESP_DLY;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 200) begin @(negedge clk); #3; t++; end
        if (obs_q.size() < n) begin
            n_total++;
            $display("FAIL obs_timeout got %0d frames required %0d", obs_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || pend || src_q[0].size() || src_q[1].size() || src_q[2].size() || src_q[3].size()) && t < 300) begin
            @(negedge clk); #3; t++;
        end
        if (t >= 300) begin n_total++; $display("FAIL idle_timeout got busy=%b required 0", busy); end
    endtask

    task automatic test_reset();
        do_reset();
        #3;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b required 0", busy); else n_pass++;
        n_total++; if (grant !== 4'b0) $display("FAIL rst_grant got %b required 0000", grant); else n_pass++;
        n_total++; if (frames_sent !== 2'd0) $display("FAIL rst_frames got %0d required 0", frames_sent); else n_pass++;
        n_total++; if (req_ready !== 4'b0) $display("FAIL rst_ready got %b required 0000", req_ready); else n_pass++;
        n_total++; if (tx_enable !== 1'b0) $display("FAIL rst_txen got %b required 0", tx_enable); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL rst_txdata got %h required 00", tx_data); else n_pass++;
        n_total++; if (b_busy !== 1'b0 || b_frames !== 16'd0) $display("FAIL rst_gap_inst got busy=%b frames=%0d required 0/0", b_busy, b_frames); else n_pass++;
    endtask

    task automatic test_single();
        logic [N+DW-1:0] e, o;
        do_reset();
        @(negedge clk); #3;
        src_q[0].push_back({1'b0, 8'hA5});
        exp_q.push_back({onehot(0), 8'hA5});
        @(negedge clk); #3;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL t1_ready got %b required 0001", req_ready); else n_pass++;
        n_total++; if (tx_enable !== 1'b0) $display("FAIL t1_txen_pre got %b required 0", tx_enable); else n_pass++;
        @(negedge clk); #3;
        n_total++; if (tx_enable !== 1'b1) $display("FAIL t1_txen_post got %b required 1", tx_enable); else n_pass++;
        n_total++; if (tx_data !== 8'hA5) $display("FAIL t1_txdata got %h required a5", tx_data); else n_pass++;
        n_total++; if (busy !== 1'b1 || grant !== 4'b0001 || req_ready !== 4'b0) $display("FAIL t1_xfer got busy=%b grant=%b ready=%b required 1/0001/0000", busy, grant, req_ready); else n_pass++;
        wait_obs(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            n_total++; if (o !== e) $display("FAIL t1_frame got %h required %h", o, e); else n_pass++;
        end
        wait_idle();
        n_total++; if (frames_sent !== 2'd1 || grant !== 4'b0) $display("FAIL t1_done got frames=%0d grant=%b required 1/0000", frames_sent, grant); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N+DW-1:0] e, o;
        int c [5];
        do_reset();
        @(negedge clk); #3;
        for (int i = 0; i < N; i++) src_q[i].push_back({1'b0, 8'h10 + 8'(i)});
        src_q[0].push_back({1'b0, 8'h10});
        for (int i = 0; i < 5; i++) exp_q.push_back({onehot(i % N), 8'h10 + 8'(i % N)});
        wait_obs(5);
        for (int i = 0; i < 5; i++) c[i] = (obs_cyc.size() > 0) ? obs_cyc.pop_front() : 0;
        for (int i = 1; i < 5; i++) begin
            n_total++; if (c[i] - c[i-1] !== RESP_DLY + 2) $display("FAIL t2_spacing%0d got %0d cycles required %0d", i, c[i] - c[i-1], RESP_DLY + 2); else n_pass++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL t2_frame got %h required %h", o, e); else n_pass++;
        end
        wait_idle();
        n_total++; if (frames_sent !== 2'd1) $display("FAIL t6_wrap got %0d required 1", frames_sent); else n_pass++;
    endtask

    task automatic test_lock();
        logic [N+DW-1:0] e, o;
        do_reset();
        @(negedge clk); #3;
        src_q[1].push_back({1'b0, 8'h21});
        exp_q.push_back({onehot(1), 8'h21});
        wait_obs(1);
        src_q[0].push_back({1'b0, 8'h01});
        src_q[1].push_back({1'b0, 8'h22});
        src_q[2].push_back({1'b1, 8'h31});
        src_q[2].push_back({1'b1, 8'h32});
        src_q[2].push_back({1'b0, 8'h33});
        exp_q.push_back({onehot(2), 8'h31});
        exp_q.push_back({onehot(2), 8'h32});
        exp_q.push_back({onehot(2), 8'h33});
        exp_q.push_back({onehot(0), 8'h01});
        exp_q.push_back({onehot(1), 8'h22});
        wait_obs(6);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            n_total++; if (o !== e) $display("FAIL t3_frame got %h required %h", o, e); else n_pass++;
        end
        wait_idle();
    endtask

    task automatic test_gap();
        int first;
        logic [N-1:0] rdy_at;
        @(negedge clk);
        b_data  = {8'h44, 8'h43, 8'h42, 8'h41};
        b_valid = 4'b0011;
        #3;
        n_total++; if (b_ready !== 4'b0001) $display("FAIL t4_ready0 got %b required 0001", b_ready); else n_pass++;
        @(negedge clk); b_valid = 4'b0010; #3;
        n_total++; if (b_txd !== 8'h41 || b_grant !== 4'b0001 || b_busy !== 1'b1) $display("FAIL t4_xfer0 got data=%h grant=%b busy=%b required 41/0001/1", b_txd, b_grant, b_busy); else n_pass++;
        @(negedge clk); @(negedge clk); b_resp = 1'b1;
        @(negedge clk); b_resp = 1'b0;
        first = 0; rdy_at = '0;
        for (int k = 1; k <= 8; k++) begin
            #3;
            if (first == 0 && b_ready !== 4'b0) begin first = k; rdy_at = b_ready; end
            @(negedge clk);
        end
        n_total++; if (first !== 6) $display("FAIL t4_gap_latency got %0d cycles required 6", first); else n_pass++;
        n_total++; if (rdy_at !== 4'b0010) $display("FAIL t4_ready1 got %b required 0010", rdy_at); else n_pass++;
        b_valid = 4'b0; #3;
        n_total++; if (b_txd !== 8'h42 || b_grant !== 4'b0010 || b_frames !== 16'd1) $display("FAIL t4_xfer1 got data=%h grant=%b frames=%0d required 42/0010/1", b_txd, b_grant, b_frames); else n_pass++;
        @(negedge clk); b_resp = 1'b1;
        @(negedge clk); b_resp = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        n_total++; if (b_busy !== 1'b0 || b_frames !== 16'd2 || b_grant !== 4'b0) $display("FAIL t4_done got busy=%b frames=%0d grant=%b required 0/2/0000", b_busy, b_frames, b_grant); else n_pass++;
    endtask

    task automatic test_reset_mid_xfer();
        logic [N+DW-1:0] e, o;
        logic lvl_hold;
        do_reset();
        @(negedge clk); #3;
        src_q[0].push_back({1'b0, 8'h3C});
        exp_q.push_back({onehot(0), 8'h3C});
        wait_obs(1);
        lvl_hold = lvl;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        src_q[1].push_back({1'b0, 8'h5A});
        exp_q.push_back({onehot(1), 8'h5A});
        @(negedge clk); #3;
        n_total++; if (busy !== 1'b1) $display("FAIL t5_busy got %b required 1", busy); else n_pass++;
        n_total++; if (req_ready !== 4'b0) $display("FAIL t5_ready got %b required 0000", req_ready); else n_pass++;
        n_total++; if (tx_enable !== lvl_hold) $display("FAIL t5_txen got %b required %b", tx_enable, lvl_hold); else n_pass++;
        n_total++; if (grant !== 4'b0 || frames_sent !== 2'd0) $display("FAIL t5_cleared got grant=%b frames=%0d required 0000/0", grant, frames_sent); else n_pass++;
        wait_obs(2);
        n_total++; if (frames_sent !== 2'd0) $display("FAIL t5_flush_nocount got %0d required 0", frames_sent); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            n_total++; if (o !== e) $display("FAIL t5_frame got %h required %h", o, e); else n_pass++;
        end
        wait_idle();
        n_total++; if (frames_sent !== 2'd1) $display("FAIL t5_done got %0d required 1", frames_sent); else n_pass++;
    endtask

    task automatic test_spurious();
        logic [N+DW-1:0] e, o;
        @(negedge clk); resp_spur = 1'b1;
        @(negedge clk); resp_spur = 1'b0;
        #3;
        n_total++; if (frames_sent !== 2'd1 || busy !== 1'b0) $display("FAIL t6_spurious got frames=%0d busy=%b required 1/0", frames_sent, busy); else n_pass++;
        src_q[3].push_back({1'b0, 8'h77});
        exp_q.push_back({onehot(3), 8'h77});
        wait_obs(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            n_total++; if (o !== e) $display("FAIL t6_frame got %h required %h", o, e); else n_pass++;
        end
        wait_idle();
        n_total++; if (frames_sent !== 2'd2) $display("FAIL t6_after got %0d required 2", frames_sent); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; resp_spur = 1'b0;
        b_valid = '0; b_lock = '0; b_data = '0; b_resp = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_gap();
        test_reset_mid_xfer();
        test_spurious();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
